// File: rtl/rot_imm_encoder.sv
// Sequential encoder for the 32-bit rotated-immediate operand: finds the smallest rot4 with
// ROR(imm8, 2*rot4) == value. Define ROT_IMM_INV_SEARCH_EN to add a second pass on ~value.
module rot_imm_encoder #(
    parameter int MAX_ROT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] imm12,
    output logic        inv
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROT = 4'(MAX_ROT);

    state_t      state_q, state_d;
    logic [31:0] vreg_q, vreg_d;
    logic [3:0]  rot_q, rot_d;
    logic        found_q, found_d;
    logic [11:0] imm12_q, imm12_d;
`ifdef ROT_IMM_INV_SEARCH_EN
    logic        inv_q, inv_d;
`endif

    logic [4:0]  rol_amt;
    logic [5:0]  ror_amt;
    logic [31:0] cand;

    // A left shift by zero pairs with a right shift by 32, which yields zero, so rot 0 is exact.
    assign rol_amt = {rot_q, 1'b0};
    assign ror_amt = 6'd32 - {1'b0, rol_amt};
    assign cand    = (vreg_q << rol_amt) | (vreg_q >> ror_amt);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        vreg_d  = vreg_q;
        rot_d   = rot_q;
        found_d = found_q;
        imm12_d = imm12_q;
`ifdef ROT_IMM_INV_SEARCH_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vreg_d  = value;
                    rot_d   = 4'd0;
                    found_d = 1'b0;
                    imm12_d = 12'd0;
`ifdef ROT_IMM_INV_SEARCH_EN
                    inv_d   = 1'b0;
`endif
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cand[31:8] == 24'd0) begin
                    imm12_d = {rot_q, cand[7:0]};
                    found_d = 1'b1;
                    state_d = S_DONE;
                end else if (rot_q == LAST_ROT) begin
`ifdef ROT_IMM_INV_SEARCH_EN
                    // Direct pass exhausted: restart on the complement so MVN/BIC forms are found.
                    if (!inv_q) begin
                        vreg_d = ~vreg_q;
                        rot_d  = 4'd0;
                        inv_d  = 1'b1;
                    end else begin
                        found_d = 1'b0;
                        imm12_d = 12'd0;
                        inv_d   = 1'b0;
                        state_d = S_DONE;
                    end
`else
                    found_d = 1'b0;
                    imm12_d = 12'd0;
                    state_d = S_DONE;
`endif
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vreg_q  <= 32'd0;
            rot_q   <= 4'd0;
            found_q <= 1'b0;
            imm12_q <= 12'd0;
`ifdef ROT_IMM_INV_SEARCH_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vreg_q  <= vreg_d;
            rot_q   <= rot_d;
            found_q <= found_d;
            imm12_q <= imm12_d;
`ifdef ROT_IMM_INV_SEARCH_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign busy  = (state_q == S_SEARCH);
    assign done  = (state_q == S_DONE);
    assign found = found_q;
    assign imm12 = imm12_q;
`ifdef ROT_IMM_INV_SEARCH_EN
    assign inv   = inv_q;
`else
    assign inv   = 1'b0;
`endif

endmodule

// File: tb/tb_rot_imm_encoder.sv
// Scoreboard bench for rot_imm_encoder: expectations are queued at start and checked on done.
module tb_rot_imm_encoder;

    localparam int MAX_ROT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic        busy, done, found, inv;
    logic [11:0] imm12;

    rot_imm_encoder #(.MAX_ROT(MAX_ROT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .value(value),
        .busy (busy),
        .done (done),
        .found(found),
        .imm12(imm12),
        .inv  (inv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        logic        f;
        logic [11:0] imm;
        logic        iv;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        int k;
        k = s % 32;
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    // Reference: smallest rotation whose decoded immediate reproduces the constant.
    function automatic exp_t model(input logic [31:0] v);
        exp_t        e;
        logic [31:0] vv;
        logic [7:0]  im;
        int          passes;
`ifdef ROT_IMM_INV_SEARCH_EN
        passes = 2;
`else
        passes = 1;
`endif
        e = '{v, 1'b0, 12'd0, 1'b0, passes * (MAX_ROT + 1) + 1, 0};
        for (int p = 0; p < passes; p++) begin
            vv = (p == 0) ? v : ~v;
            for (int r = 0; r <= MAX_ROT; r++) begin
                im = ror32(vv, 32 - 2 * r) & 32'hFF;
                if (ror32({24'd0, im}, 2 * r) == vv) begin
                    e.f   = 1'b1;
                    e.imm = {4'(r), im};
                    e.iv  = (p == 1);
                    e.lat = p * (MAX_ROT + 1) + r + 2;
                    return e;
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] dec;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("done_without_request", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("found", {31'd0, found}, {31'd0, e.f});
                check("imm12", {20'd0, imm12}, {20'd0, e.imm});
                check("inv", {31'd0, inv}, {31'd0, e.iv});
                check("latency", cyc - e.t0, e.lat);
                check("busy_at_done", {31'd0, busy}, 32'd0);
                if (found) begin
                    dec = ror32({24'd0, imm12[7:0]}, 2 * int'(imm12[11:8]));
                    check("round_trip", dec, inv ? ~e.v : e.v);
                end
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            check("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] v, input logic f, input logic [11:0] im,
                       input logic iv, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        value = v;
        e = '{v, f, im, iv, lat, cyc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
        wait_empty();
        check("held_found", {31'd0, found}, {31'd0, f});
        check("held_imm12", {20'd0, imm12}, {20'd0, im});
    endtask

    task automatic run_model(input logic [31:0] v);
        exp_t e;
        e = model(v);
        run(v, e.f, e.imm, e.iv, e.lat);
    endtask

    initial begin
        int          n0;
        exp_t        e;
        logic [31:0] v;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_imm12", {20'd0, imm12}, 32'd0);
        check("rst_inv", {31'd0, inv}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 2);
        run(32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 6);
        run(32'h0000_0104, 1'b1, 12'hF41, 1'b0, 17);
`ifdef ROT_IMM_INV_SEARCH_EN
        run(32'h0000_0101, 1'b0, 12'h000, 1'b0, 33);
        run(32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b1, 18);
`else
        run(32'h0000_0101, 1'b0, 12'h000, 1'b0, 17);
        run(32'hFFFF_FF00, 1'b0, 12'h000, 1'b0, 17);
`endif
        run(32'h0000_0000, 1'b1, 12'h000, 1'b0, 2);

        // Extra start pulses in SEARCH and in the done cycle must be dropped.
        @(posedge clk);
        #1;
        n0 = n_done;
        start = 1'b1;
        value = 32'h0000_0003;
        e = '{32'h0000_0003, 1'b1, 12'h003, 1'b0, 2, cyc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        value = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty();
        repeat (40) @(posedge clk);
        #1;
        check("single_done", n_done - n0, 1);
        check("ignored_keep_imm12", {20'd0, imm12}, 32'h003);

        // Reset in the middle of a failing search.
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'h0000_0101;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_found", {31'd0, found}, 32'd0);
        check("mid_rst_imm12", {20'd0, imm12}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_done;
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_abort", n_done - n0, 0);
        run(32'h0000_0000, 1'b1, 12'h000, 1'b0, 2);

        for (int i = 0; i < 16; i++) begin
            case (i % 3)
                0: v = ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
                1: v = ~ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
                default: v = $urandom;
            endcase
            run_model(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
